// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the unified MIPS memory port.
// Imported by the arbiter and its address translator.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic REGION_TEXT = 1'b0;
  localparam logic REGION_DATA = 1'b1;

  // Width of a counter stepping through the read latency.
  function automatic int lat_cnt_w(input int lat);
    return (lat <= 1) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_addr_xlate.sv
// Byte address to region word index, with alignment/range error.
// One instance per requester; base and region bit are parameters.
module mem_addr_xlate
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_SIZE = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE = '0,
  parameter logic REGION = REGION_TEXT
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_SIZE:0]    index,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] SPAN =
    ADDR_WIDTH'(4) << ADDR_SIZE;

  logic [ADDR_WIDTH-1:0] off;
  logic below;

  assign off = addr - BASE;

  // A zero base cannot underflow, so skip the compare.
  if (BASE == '0) begin : g_nobase
    assign below = 1'b0;
  end else begin : g_base
    assign below = addr < BASE;
  end

  assign index = {REGION, off[ADDR_SIZE+1:2]};
  assign err = (addr[1:0] != 2'b00)
             | below
             | (off >= SPAN);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified I/D memory between fetch and data ports.
// One access in flight; fixed read latency; one-cycle acks.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_SIZE = 8,
  parameter logic [ADDR_WIDTH-1:0] DATA_BASE_ADDRESS = 'h40_0000,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ack,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_SIZE:0]    mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = lat_cnt_w(MEM_LATENCY);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX =
    SW'(MAX_DATA_STREAK);

  state_t state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_inc;
  logic own_dm;
  logic own_we;

  logic [ADDR_SIZE:0] if_idx;
  logic [ADDR_SIZE:0] dm_idx;
  logic if_bad;
  logic dm_bad;
  logic dm_win;
  logic if_win;
  logic win_bad;

  mem_addr_xlate #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .ADDR_SIZE (ADDR_SIZE),
    .BASE      ('0),
    .REGION    (REGION_TEXT)
  ) u_if_xlate (
    .addr (if_addr),
    .index(if_idx),
    .err  (if_bad)
  );

  mem_addr_xlate #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .ADDR_SIZE (ADDR_SIZE),
    .BASE      (DATA_BASE_ADDRESS),
    .REGION    (REGION_DATA)
  ) u_dm_xlate (
    .addr (dm_addr),
    .index(dm_idx),
    .err  (dm_bad)
  );

  // Data wins unless it has starved fetch long enough.
  assign dm_win  = dm_req &&
                   !(if_req && streak == STREAK_MAX);
  assign if_win  = if_req && !dm_win;
  assign win_bad = dm_win ? dm_bad : if_bad;

  assign streak_inc = (streak == STREAK_MAX) ?
                      streak : streak + SW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      own_dm    <= 1'b0;
      own_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      dm_ack    <= 1'b0;
      dm_rdata  <= '0;
      dm_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          streak <= dm_win ? streak_inc : '0;
          own_dm <= dm_win;
          own_we <= dm_win && dm_we;
          if (dm_win || if_win) begin
            if (win_bad) begin
              state <= RESP;
              if (dm_win) begin
                dm_ack   <= 1'b1;
                dm_err   <= 1'b1;
                dm_rdata <= '0;
              end else begin
                if_ack   <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end
            end else begin
              state     <= ISSUE;
              mem_en    <= 1'b1;
              mem_we    <= dm_win && dm_we;
              mem_addr  <= dm_win ? dm_idx : if_idx;
              mem_wdata <= dm_win ? dm_wdata : '0;
            end
          end
        end
        ISSUE: begin
          state  <= WAIT;
          cnt    <= '0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= RESP;
            if (own_dm) begin
              dm_ack   <= 1'b1;
              dm_err   <= 1'b0;
              dm_rdata <= own_we ? '0 : mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_err   <= 1'b0;
              if_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          state  <= IDLE;
          if_ack <= 1'b0;
          if_err <= 1'b0;
          dm_ack <= 1'b0;
          dm_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single unified instruction/data memory of the MIPS core between two requesters: the instruction-fetch port (IF) and the load/store data port (DM). It sits between the core's fetch/memory stages and the memory array. It arbitrates, translates byte addresses into word indices for a two-region memory (text, data), and issues one memory access at a time with a fixed read latency. It returns a one-cycle acknowledge with read data or an error flag.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width on requester ports
- ADDR_SIZE, 8, log2 words per region; memory depth is 2^(ADDR_SIZE+1)
- DATA_BASE_ADDRESS, 'h40_0000, byte address of data region word 0
- MEM_LATENCY, 2, cycles from mem_en to valid mem_rdata (>=1)
- MAX_DATA_STREAK, 4, consecutive DM grants allowed while IF waits
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  DATA_WIDTH  instruction word, valid with if_ack
- if_err  out  1  bad address, valid with if_ack
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data byte address
- dm_wdata  in  DATA_WIDTH  store data
- dm_ack, dm_rdata, dm_err  out  1/DATA_WIDTH/1  as IF equivalents
- mem_en  out  1  access strobe, one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_SIZE+1  word index; MSB 0 = text, 1 = data
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset value: all outputs 0, state IDLE, streak counter 0.
- IDLE samples requests and picks a winner:
  - DM wins unless the streak counter equals MAX_DATA_STREAK and if_req=1; then IF wins.
  - A DM grant increments the streak counter, saturating.
  - An IF grant clears it. IDLE with no DM request clears it.
- Address translation:
  - IF: index = {1'b0, if_addr[ADDR_SIZE+1:2]}.
  - DM: index = {1'b1, off[ADDR_SIZE+1:2]}, where off = dm_addr - DATA_BASE_ADDRESS (ADDR_WIDTH-bit subtract).
- Error condition: addr[1:0] != 0, IF address >= 4*2^ADDR_SIZE, DM address < DATA_BASE_ADDRESS, or off >= 4*2^ADDR_SIZE.
  - On error: IDLE goes directly to RESP with err=1 and rdata=0.
  - No mem_en is issued. The streak counter is still updated.
- ISSUE: mem_en=1, mem_we=dm_we (0 for IF), mem_addr and mem_wdata registered from the winner.
- WAIT: lasts MEM_LATENCY cycles. In the last WAIT cycle, mem_rdata is captured into the winner's rdata register. Stores are acknowledged after the same latency with rdata=0.
- RESP: the winner's ack=1 for exactly one cycle, then IDLE. Requests are not sampled in RESP.
- Requesters hold addr/wdata/we stable from req rising until ack. After ack, a requester may keep req high only if it is presenting a new transaction.
- Reset asserted in any state aborts the access immediately: no ack, outputs return to reset values.

## Timing
- All outputs are registered.
- Request sampled in IDLE at cycle T:
  - mem_en in cycle T+1.
  - mem_rdata valid at T+1+MEM_LATENCY.
  - ack and rdata in cycle T+2+MEM_LATENCY.
- Request-to-ack latency is MEM_LATENCY+2. Error-path latency is 1 (ack in T+1).
- Minimum spacing between successive mem_en pulses is MEM_LATENCY+3 cycles.
- Both requests arriving in the same cycle: DM is served first. IF is sampled in the IDLE cycle after DM's RESP.

## Structure
- Package mips_mem_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - region select constants REGION_TEXT=0, REGION_DATA=1
  - MEM_LATENCY counter width function
- One sub-module, mem_addr_xlate: combinational translation of one byte address to {index, err}, parameterised by region base and region bit. It is instantiated once per requester.

## Test plan
- Reset: hold reset=0 for 10 cycles with both reqs high -> no mem_en, all acks 0. Release -> first mem_en one cycle after the first IDLE cycle.
- Single fetch (L=2): if_addr=0x0000_0010 -> mem_en at T+1 with mem_addr=0x004, mem_we=0. if_ack at T+4 with if_rdata = memory word.
- Store then load: store dm_addr=0x0040_0008, dm_wdata=0xDEADBEEF -> mem_addr=0x102, mem_we=1. A following load from the same address -> dm_rdata=0xDEADBEEF.
- Simultaneous: if_req and dm_req rise together -> dm_ack first, then if_ack exactly MEM_LATENCY+3 cycles later.
- Starvation: dm_req held continuously with if_req=1 -> exactly 4 DM grants, then 1 IF grant, then DM grants resume.
- Errors and mid-access reset:
  - dm_addr=0x0000_0100 -> dm_err=1, dm_ack at T+1, no mem_en.
  - if_addr=0x0000_0002 -> if_err=1.
  - reset asserted during WAIT -> no ack; outputs return to 0 asynchronously.
